// File: rtl/csr_avmm_arbiter.sv
// csr_avmm_arbiter: round-robin arbiter sharing one CSR Avalon-MM master
// port among N_REQ requesters. One transaction is in flight at a time; the
// grant is held until a write is accepted downstream or a read's data returns.
// Read data is routed back to the requester that was granted.
//
// Optional feature: define CSR_AVMM_ARBITER_TIMEOUT_EN to enable a read
// timeout. If a read gets no response within TIMEOUT_CYC cycles, the arbiter
// returns all-ones to the requester and sets the sticky timeout_err flag.
// Without the macro, the arbiter waits indefinitely for read data and
// timeout_err is tied to 0.
module csr_avmm_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_read,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ*ADDR_W-1:0]     req_address,
    input  logic [N_REQ*DATA_W-1:0]     req_writedata,
    input  logic [N_REQ*DATA_W/8-1:0]   req_byteenable,
    output logic [N_REQ-1:0]            req_waitrequest,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [N_REQ-1:0]            req_readdatavalid,
    output logic                        m_read,
    output logic                        m_write,
    output logic [ADDR_W-1:0]           m_address,
    output logic [DATA_W-1:0]           m_writedata,
    output logic [DATA_W/8-1:0]         m_byteenable,
    input  logic                        m_waitrequest,
    input  logic [DATA_W-1:0]           m_readdata,
    input  logic                        m_readdatavalid,
    output logic                        timeout_err
);

    localparam int BE_W = DATA_W / 8;
    localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [GW-1:0] ptr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_ACK,
        S_WAIT_RD
    } state_t;

    state_t              r_state;
    ptr_t                r_rr;
    ptr_t                r_grant;
    logic                r_is_write;
    logic [N_REQ-1:0]    r_wreq;
    logic [DATA_W-1:0]   r_rdata;
    logic [N_REQ-1:0]    r_rdv;
    logic                r_m_read;
    logic                r_m_write;
    logic [ADDR_W-1:0]   r_m_address;
    logic [DATA_W-1:0]   r_m_writedata;
    logic [BE_W-1:0]     r_m_byteenable;

    logic                w_found;
    ptr_t                w_grant;
    int                  w_idx;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [BE_W-1:0]     w_sel_be;

`ifdef CSR_AVMM_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_timeout_err;
`endif

    // Round-robin pointer advance: the granted requester goes to the back.
    function automatic ptr_t next_ptr(input ptr_t p);
        if (p == ptr_t'(N_REQ - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Pick the first active requester at or after the round-robin pointer.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_found = 1'b0;
        w_grant = r_rr;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && (req_read[w_idx] || req_write[w_idx])) begin
                w_found = 1'b1;
                w_grant = ptr_t'(w_idx);
            end
        end
    end

    // Operands of the candidate winner; a write wins over a simultaneous read.
    assign w_sel_write = req_write[w_grant];
    assign w_sel_addr  = req_address[int'(w_grant)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_writedata[int'(w_grant)*DATA_W +: DATA_W];
    assign w_sel_be    = req_byteenable[int'(w_grant)*BE_W +: BE_W];

    // Main FSM: arbitration, downstream command, ack and read-data return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_rr           <= '0;
            r_grant        <= '0;
            r_is_write     <= 1'b0;
            r_wreq         <= '1;
            r_rdata        <= '0;
            r_rdv          <= '0;
            r_m_read       <= 1'b0;
            r_m_write      <= 1'b0;
            r_m_address    <= '0;
            r_m_writedata  <= '0;
            r_m_byteenable <= '0;
`ifdef CSR_AVMM_ARBITER_TIMEOUT_EN
            r_to_cnt       <= '0;
            r_timeout_err  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; the per-cycle defaults
            // below are overridden by later assignments in the same block.
            r_wreq <= '1;
            r_rdv  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant        <= w_grant;
                        r_is_write     <= w_sel_write;
                        r_m_write      <= w_sel_write;
                        r_m_read       <= !w_sel_write;
                        r_m_address    <= w_sel_addr;
                        r_m_writedata  <= w_sel_wdata;
                        r_m_byteenable <= w_sel_be;
                        r_state        <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (!m_waitrequest) begin
                        r_m_read         <= 1'b0;
                        r_m_write        <= 1'b0;
                        r_wreq[r_grant]  <= 1'b0;
                        r_state          <= S_ACK;
`ifdef CSR_AVMM_ARBITER_TIMEOUT_EN
                        r_to_cnt         <= '0;
`endif
                    end
                end
                S_ACK, S_WAIT_RD: begin
                    if (r_state == S_ACK && r_is_write) begin
                        r_rr    <= next_ptr(r_grant);
                        r_state <= S_IDLE;
                    end else if (m_readdatavalid) begin
                        r_rdata        <= m_readdata;
                        r_rdv[r_grant] <= 1'b1;
                        r_rr           <= next_ptr(r_grant);
                        r_state        <= S_IDLE;
                    end else begin
`ifdef CSR_AVMM_ARBITER_TIMEOUT_EN
                        if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            r_rdata        <= '1;
                            r_rdv[r_grant] <= 1'b1;
                            r_timeout_err  <= 1'b1;
                            r_rr           <= next_ptr(r_grant);
                            r_state        <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                            r_state  <= S_WAIT_RD;
                        end
`else
                        r_state <= S_WAIT_RD;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_waitrequest   = r_wreq;
    assign req_readdata      = r_rdata;
    assign req_readdatavalid = r_rdv;
    assign m_read            = r_m_read;
    assign m_write           = r_m_write;
    assign m_address         = r_m_address;
    assign m_writedata       = r_m_writedata;
    assign m_byteenable      = r_m_byteenable;

`ifdef CSR_AVMM_ARBITER_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_csr_avmm_arbiter.sv
// tb_csr_avmm_arbiter: directed testbench for csr_avmm_arbiter with N_REQ=2,
// ADDR_W=18, DATA_W=64, TIMEOUT_CYC=16. Inputs change 1 ns after each rising
// edge and outputs are sampled at the same point, so every value observed
// reflects the state registered on the preceding edge.
module tb_csr_avmm_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 64;
    localparam int BE_W   = DATA_W / 8;
    localparam int TO_CYC = 16;

    logic                      clk;
    logic                      rst_n;
    logic [N_REQ-1:0]          req_read;
    logic [N_REQ-1:0]          req_write;
    logic [N_REQ*ADDR_W-1:0]   req_address;
    logic [N_REQ*DATA_W-1:0]   req_writedata;
    logic [N_REQ*BE_W-1:0]     req_byteenable;
    logic [N_REQ-1:0]          req_waitrequest;
    logic [DATA_W-1:0]         req_readdata;
    logic [N_REQ-1:0]          req_readdatavalid;
    logic                      m_read;
    logic                      m_write;
    logic [ADDR_W-1:0]         m_address;
    logic [DATA_W-1:0]         m_writedata;
    logic [BE_W-1:0]           m_byteenable;
    logic                      m_waitrequest;
    logic [DATA_W-1:0]         m_readdata;
    logic                      m_readdatavalid;
    logic                      timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    csr_avmm_arbiter #(
        .N_REQ      (N_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_address      (req_address),
        .req_writedata    (req_writedata),
        .req_byteenable   (req_byteenable),
        .req_waitrequest  (req_waitrequest),
        .req_readdata     (req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_address        (m_address),
        .m_writedata      (m_writedata),
        .m_byteenable     (m_byteenable),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata,
                           input logic [BE_W-1:0] be);
        req_read[i]                          = rd;
        req_write[i]                         = wr;
        req_address[i*ADDR_W +: ADDR_W]      = addr;
        req_writedata[i*DATA_W +: DATA_W]    = wdata;
        req_byteenable[i*BE_W +: BE_W]       = be;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".wreq"},  64'(req_waitrequest), 64'h3);
        check({tag, ".rdv"},   64'(req_readdatavalid), 64'h0);
        check({tag, ".rdata"}, req_readdata, 64'h0);
        check({tag, ".mrd"},   64'(m_read), 64'h0);
        check({tag, ".mwr"},   64'(m_write), 64'h0);
        check({tag, ".maddr"}, 64'(m_address), 64'h0);
        check({tag, ".mwd"},   m_writedata, 64'h0);
        check({tag, ".mbe"},   64'(m_byteenable), 64'h0);
        check({tag, ".terr"},  64'(timeout_err), 64'h0);
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_addr;

        rst_n           = 1'b0;
        req_read        = '0;
        req_write       = '0;
        req_address     = '0;
        req_writedata   = '0;
        req_byteenable  = '0;
        m_waitrequest   = 1'b0;
        m_readdata      = '0;
        m_readdatavalid = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();

        // Single write from requester 0
        set_req(0, 1'b0, 1'b1, 18'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        tick();
        check("wr.mwr",   64'(m_write), 64'h1);
        check("wr.mrd",   64'(m_read), 64'h0);
        check("wr.maddr", 64'(m_address), 64'h100);
        check("wr.mwd",   m_writedata, 64'hDEADBEEF_CAFEF00D);
        check("wr.mbe",   64'(m_byteenable), 64'hFF);
        check("wr.wreq1", 64'(req_waitrequest), 64'h3);
        tick();
        check("wr.wreq2", 64'(req_waitrequest), 64'h2);
        check("wr.mwr2",  64'(m_write), 64'h0);
        set_req(0, 1'b0, 1'b0, 18'h0, 64'h0, 8'h0);
        tick();
        check("wr.wreq3", 64'(req_waitrequest), 64'h3);

        // Single read from requester 1, data returns a few cycles later
        set_req(1, 1'b1, 1'b0, 18'h20, 64'h0, 8'h0F);
        tick();
        check("rd.mrd",   64'(m_read), 64'h1);
        check("rd.mwr",   64'(m_write), 64'h0);
        check("rd.maddr", 64'(m_address), 64'h20);
        tick();
        check("rd.wreq",  64'(req_waitrequest), 64'h1);
        set_req(1, 1'b0, 1'b0, 18'h0, 64'h0, 8'h0);
        tick();
        tick();
        check("rd.rdv_wait", 64'(req_readdatavalid), 64'h0);
        m_readdatavalid = 1'b1;
        m_readdata      = 64'h1234;
        tick();
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        check("rd.rdv",   64'(req_readdatavalid), 64'h2);
        check("rd.rdata", req_readdata, 64'h1234);
        tick();
        check("rd.rdv_off", 64'(req_readdatavalid), 64'h0);

        // Contention: both requesters hold writes, pointer is back at 0
        set_req(0, 1'b0, 1'b1, 18'hA0, 64'h0A, 8'h01);
        set_req(1, 1'b0, 1'b1, 18'hB0, 64'h0B, 8'h02);
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 18'hA0 : 18'hB0;
            tick();
            check($sformatf("rr.addr%0d", k), 64'(m_address), 64'(exp_addr));
            tick();
            check($sformatf("rr.wreq%0d", k), 64'(req_waitrequest),
                  (k % 2 == 0) ? 64'h2 : 64'h1);
            tick();
        end
        set_req(0, 1'b0, 1'b0, 18'h0, 64'h0, 8'h0);
        set_req(1, 1'b0, 1'b0, 18'h0, 64'h0, 8'h0);
        tick();

        // Backpressure on a read from requester 0
        m_waitrequest = 1'b1;
        set_req(0, 1'b1, 1'b0, 18'h33, 64'h0, 8'hFF);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp.mrd%0d", i),   64'(m_read), 64'h1);
            check($sformatf("bp.maddr%0d", i), 64'(m_address), 64'h33);
            check($sformatf("bp.wreq%0d", i),  64'(req_waitrequest), 64'h3);
            tick();
        end
        m_waitrequest = 1'b0;
        tick();
        check("bp.mrd_off", 64'(m_read), 64'h0);
        check("bp.wreq",    64'(req_waitrequest), 64'h2);
        set_req(0, 1'b0, 1'b0, 18'h0, 64'h0, 8'h0);
        // Data arrives in the ACK cycle itself
        m_readdatavalid = 1'b1;
        m_readdata      = 64'h55AA;
        tick();
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        check("bp.rdv",   64'(req_readdatavalid), 64'h1);
        check("bp.rdata", req_readdata, 64'h55AA);
        tick();

        // Reset in WAIT_RD, late response after release is dropped
        set_req(1, 1'b1, 1'b0, 18'h44, 64'h0, 8'h0);
        tick();
        tick();
        set_req(1, 1'b0, 1'b0, 18'h0, 64'h0, 8'h0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_readdatavalid = 1'b1;
        m_readdata      = 64'h77;
        tick();
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        check_reset_values("mrst");
        tick();
        check("mrst.rdv2", 64'(req_readdatavalid), 64'h0);

        // Read with no response: timeout (macro) or indefinite wait (default)
        set_req(0, 1'b1, 1'b0, 18'h60, 64'h0, 8'h0);
        tick();
        tick();
        set_req(0, 1'b0, 1'b0, 18'h0, 64'h0, 8'h0);
`ifdef CSR_AVMM_ARBITER_TIMEOUT_EN
        for (int i = 0; i < TO_CYC - 1; i++) begin
            tick();
            check($sformatf("to.rdv%0d", i), 64'(req_readdatavalid), 64'h0);
        end
        tick();
        check("to.rdv",   64'(req_readdatavalid), 64'h1);
        check("to.rdata", req_readdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("to.terr",  64'(timeout_err), 64'h1);
        tick();
        check("to.terr_hold", 64'(timeout_err), 64'h1);
        check("to.rdv_off",   64'(req_readdatavalid), 64'h0);
`else
        for (int i = 0; i < 3 * TO_CYC; i++) begin
            tick();
            if (i % TO_CYC == TO_CYC - 1) begin
                check($sformatf("nto.rdv%0d", i),  64'(req_readdatavalid), 64'h0);
                check($sformatf("nto.terr%0d", i), 64'(timeout_err), 64'h0);
            end
        end
        // Still waiting: a response now is delivered
        m_readdatavalid = 1'b1;
        m_readdata      = 64'h9999;
        tick();
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        check("nto.rdv",   64'(req_readdatavalid), 64'h1);
        check("nto.rdata", req_readdata, 64'h9999);
`endif
        tick();

        // Illegal read+write on one requester: the write wins
        set_req(1, 1'b1, 1'b1, 18'h7F, 64'h42, 8'h3C);
        tick();
        check("rw.mwr",   64'(m_write), 64'h1);
        check("rw.mrd",   64'(m_read), 64'h0);
        check("rw.maddr", 64'(m_address), 64'h7F);
        check("rw.mbe",   64'(m_byteenable), 64'h3C);
        tick();
        check("rw.wreq",  64'(req_waitrequest), 64'h1);
        set_req(1, 1'b0, 1'b0, 18'h0, 64'h0, 8'h0);
        tick();
        check("rw.idle",  64'(req_waitrequest), 64'h3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
